// File: rtl/uart_word_tx.sv
// Word-in UART transmitter: one handshake per 32-bit word, sent as 4 (or 1) back-to-back 8N1 frames.
// Optional even-parity bit per byte when UART_TX_PARITY_EN is defined.
module uart_word_tx #(
    parameter int CLK_PER_BIT = 868,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] word_data,
    input  logic        word_valid,
    input  logic        byte_mode,
    output logic        word_ready,
    output logic        busy,
    output logic        UART_TX
);

    localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [2:0]  bytes_q, bytes_d;
    logic [31:0] word_q, word_d;
    logic        tx_q, tx_d;
    logic        wrap;
    logic [7:0]  cur_d;

    assign wrap       = (cnt_q == CNT_MAX);
    assign word_ready = RST_N && (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign UART_TX    = tx_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            bytes_q   <= '0;
            word_q    <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            bytes_q   <= bytes_d;
            word_q    <= word_d;
            tx_q      <= tx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        bytes_d   = bytes_q;
        word_d    = word_q;
        tx_d      = 1'b1;

        if (state_q == IDLE) begin
            if (word_valid && word_ready) begin
                state_d   = START;
                cnt_d     = '0;
                bit_idx_d = '0;
                bytes_d   = byte_mode ? 3'd1 : 3'd4;
                // The byte to send next always sits at the outgoing end of word_q.
                if (byte_mode)
                    word_d = MSB_FIRST ? {word_data[7:0], 24'h0} : {24'h0, word_data[7:0]};
                else
                    word_d = word_data;
            end
        end else begin
            cnt_d = wrap ? '0 : cnt_q + CW'(1);
            if (wrap) begin
                case (state_q)
                    START: begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end
                    DATA: begin
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end
                    PARITY: state_d = STOP;
                    STOP: begin
                        bytes_d = bytes_q - 3'd1;
                        word_d  = MSB_FIRST ? (word_q << 8) : (word_q >> 8);
                        state_d = (bytes_q == 3'd1) ? IDLE : START;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end

        // Line level is registered from next-state values so UART_TX is glitch-free.
        cur_d = MSB_FIRST ? word_d[31:24] : word_d[7:0];
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = cur_d[bit_idx_d];
            PARITY:  tx_d = ^cur_d;
            default: tx_d = 1'b1;
        endcase
    end

endmodule
